// File: rtl/dcs_result_quant_pkg.sv
// Shared definitions for the DCSformer result post-processor.
// Holds the frame geometry, the word/bank types and the drain FSM encoding.
package dcs_pkg;
    localparam int N_WORDS = 8;
    localparam int IN_W    = 32;
    localparam int OUT_W   = 8;
    localparam int SH_W    = 5;
    localparam int IDX_W   = 3;

    typedef logic [IN_W-1:0]  dcs_word_t;
    typedef logic [IDX_W-1:0] dcs_idx_t;

    // One ping-pong bank: the captured frame plus its running max and latched shift.
    typedef struct packed {
        dcs_word_t [N_WORDS-1:0] words;
        dcs_word_t               max_val;
        dcs_idx_t                max_idx;
        logic [SH_W-1:0]         shift;
    } dcs_bank_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_st_e;
endpackage

// File: rtl/dcs_result_quant_if.sv
// Output beat stream of dcs_result_quant (valid/ready with backpressure).
//   out_valid/out_ready : handshake
//   out_data            : requantized beat
//   out_idx/out_last    : word index in the frame, high on word 7
//   max_idx/max_val     : frame maximum, valid while out_valid
// master = producer (the post-processor), slave = consumer.
interface dcs_result_quant_if;
    import dcs_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    dcs_idx_t         out_idx;
    logic             out_last;
    dcs_idx_t         max_idx;
    dcs_word_t        max_val;

    modport master (
        output out_valid, out_data, out_idx, out_last, max_idx, max_val,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_idx, out_last, max_idx, max_val,
        output out_ready
    );
endinterface

// File: rtl/dcs_result_quant_requant.sv
// Combinational requantizer: round-half-up right shift, then saturate to OUT_W.
//   x     : unsigned input word
//   shift : right-shift amount, 0 passes the word through unrounded
//   q     : saturated unsigned result
module dcs_requant
    import dcs_pkg::*;
(
    input  dcs_word_t        x,
    input  logic [SH_W-1:0]  shift,
    output logic [OUT_W-1:0] q
);
    logic [IN_W:0] rnd_s;
    logic [IN_W:0] sum_s;
    logic [IN_W:0] shr_s;

    // Round/shift in IN_W+1 bits so the rounding add cannot wrap, then clamp.
    always_comb begin
        rnd_s = '0;
        sum_s = {1'b0, x};
        shr_s = {1'b0, x};
        if (shift != '0) begin
            rnd_s = {{IN_W{1'b0}}, 1'b1} << (shift - SH_W'(1));
            sum_s = {1'b0, x} + rnd_s;
            shr_s = sum_s >> shift;
        end else begin
            rnd_s = '0;
        end
        if (|shr_s[IN_W:OUT_W]) begin
            q = {OUT_W{1'b1}};
        end else begin
            q = shr_s[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/dcs_result_quant.sv
// Post-processor for the DCSformer attention core.
// Captures 8-word frames into a two-bank ping-pong buffer (the core cannot be
// stalled), tracks the frame maximum, and drains each frame as requantized
// 8-bit beats with backpressure.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid, in_data  : core result stream, no backpressure
//   cfg_shift          : requant shift, latched with word 0 of a frame
//   clr_err            : clears the sticky ovf / frm_err flags
//   ob                 : output beat stream (master side)
//   ovf                : sticky, a frame was dropped with both banks full
//   frm_err            : sticky, in_valid dropped mid-frame
module dcs_result_quant
    import dcs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  dcs_word_t            in_data,
    input  logic [SH_W-1:0]      cfg_shift,
    input  logic                 clr_err,
    dcs_result_quant_if.master   ob,
    output logic                 ovf,
    output logic                 frm_err
);
    dcs_bank_t  bank_r [0:1];
    logic [1:0] full_r;
    dcs_idx_t   wcnt_r;
    dcs_idx_t   rcnt_r;
    logic       wptr_r;
    logic       rptr_r;
    logic       drop_r;
    drain_st_e  state_r;
    drain_st_e  state_n;

    logic             out_valid_r;
    logic [OUT_W-1:0] out_data_r;
    dcs_idx_t         out_idx_r;
    logic             out_last_r;
    dcs_idx_t         max_idx_r;
    dcs_word_t        max_val_r;
    logic             ovf_r;
    logic             frm_err_r;

    logic hs_s, rel_s, word0_s, wr_free_s, wr_en_s, fill_s, abort_s, ovf_set_s;
    logic [1:0] rel_vec_s, fill_vec_s;
    logic             ld_en_s, out_clr_s, ld_bank_s;
    dcs_idx_t         ld_idx_s;
    dcs_word_t        ld_word_s;
    logic [SH_W-1:0]  ld_shift_s;
    logic [OUT_W-1:0] q_s;

    // Capture-side and release events shared by the bank and flag logic.
    always_comb begin
        hs_s      = out_valid_r & ob.out_ready;
        rel_s     = hs_s & (rcnt_r == 3'd7);
        word0_s   = in_valid & (wcnt_r == 3'd0);
        // A bank released by this cycle's final handshake is free for word 0.
        wr_free_s = ~full_r[wptr_r] | (rel_s & (rptr_r == wptr_r));
        if (word0_s) begin
            wr_en_s = wr_free_s;
        end else begin
            wr_en_s = in_valid & ~drop_r;
        end
        fill_s     = wr_en_s & (wcnt_r == 3'd7);
        ovf_set_s  = word0_s & ~wr_free_s;
        abort_s    = ~in_valid & (wcnt_r != 3'd0);
        rel_vec_s  = rel_s  ? (2'b01 << rptr_r) : 2'b00;
        fill_vec_s = fill_s ? (2'b01 << wptr_r) : 2'b00;
    end

    // Frame capture: write counter, bank contents, running max and shift latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r    <= 3'd0;
            wptr_r    <= 1'b0;
            drop_r    <= 1'b0;
            bank_r[0] <= '0;
            bank_r[1] <= '0;
        end else if (in_valid) begin
            // Dropped frames still count so alignment to the core is kept.
            wcnt_r <= wcnt_r + 3'd1;
            if (word0_s) begin
                drop_r <= ~wr_free_s;
            end
            if (wr_en_s) begin
                bank_r[wptr_r].words[wcnt_r] <= in_data;
                if (word0_s) begin
                    bank_r[wptr_r].max_val <= in_data;
                    bank_r[wptr_r].max_idx <= 3'd0;
                    bank_r[wptr_r].shift   <= cfg_shift;
                end else if (in_data > bank_r[wptr_r].max_val) begin
                    bank_r[wptr_r].max_val <= in_data;
                    bank_r[wptr_r].max_idx <= wcnt_r;
                end
            end
            if (fill_s) begin
                wptr_r <= ~wptr_r;
            end
        end else begin
            wcnt_r <= 3'd0;
        end
    end

    // Bank full flags, drain pointers and FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r  <= 2'b00;
            rptr_r  <= 1'b0;
            rcnt_r  <= 3'd0;
            state_r <= IDLE;
        end else begin
            full_r  <= (full_r & ~rel_vec_s) | fill_vec_s;
            state_r <= state_n;
            if (hs_s) begin
                rcnt_r <= rcnt_r + 3'd1;
            end
            if (rel_s) begin
                rptr_r <= ~rptr_r;
            end
        end
    end

    // Drain next-state and output-register load selection.
    always_comb begin
        state_n   = state_r;
        ld_en_s   = 1'b0;
        out_clr_s = 1'b0;
        ld_bank_s = rptr_r;
        ld_idx_s  = rcnt_r;
        case (state_r)
            IDLE: begin
                if (full_r[rptr_r]) begin
                    state_n = STREAM;
                end else begin
                    state_n = IDLE;
                end
            end
            STREAM: begin
                if (!out_valid_r) begin
                    // First beat of a burst enters the output register.
                    ld_en_s = 1'b1;
                end else if (hs_s) begin
                    if (rcnt_r != 3'd7) begin
                        ld_en_s  = 1'b1;
                        ld_idx_s = rcnt_r + 3'd1;
                    end else if (full_r[~rptr_r]) begin
                        // Chain straight into the other bank without a bubble.
                        ld_en_s   = 1'b1;
                        ld_bank_s = ~rptr_r;
                        ld_idx_s  = 3'd0;
                    end else begin
                        out_clr_s = 1'b1;
                        state_n   = IDLE;
                    end
                end else begin
                    ld_en_s = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        ld_word_s  = bank_r[ld_bank_s].words[ld_idx_s];
        ld_shift_s = bank_r[ld_bank_s].shift;
    end

    dcs_requant u_requant (
        .x     (ld_word_s),
        .shift (ld_shift_s),
        .q     (q_s)
    );

    // Registered output beat; holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= 3'd0;
            out_last_r  <= 1'b0;
            max_idx_r   <= 3'd0;
            max_val_r   <= '0;
        end else if (ld_en_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= q_s;
            out_idx_r   <= ld_idx_s;
            out_last_r  <= (ld_idx_s == 3'd7);
            max_idx_r   <= bank_r[ld_bank_s].max_idx;
            max_val_r   <= bank_r[ld_bank_s].max_val;
        end else if (out_clr_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= 3'd0;
            out_last_r  <= 1'b0;
            max_idx_r   <= 3'd0;
            max_val_r   <= '0;
        end
    end

    // Sticky error flags; a set event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r     <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            ovf_r     <= ovf_set_s | (ovf_r & ~clr_err);
            frm_err_r <= abort_s   | (frm_err_r & ~clr_err);
        end
    end

    assign ob.out_valid = out_valid_r;
    assign ob.out_data  = out_data_r;
    assign ob.out_idx   = out_idx_r;
    assign ob.out_last  = out_last_r;
    assign ob.max_idx   = max_idx_r;
    assign ob.max_val   = max_val_r;
    assign ovf          = ovf_r;
    assign frm_err      = frm_err_r;
endmodule

// File: tb/tb_dcs_result_quant.sv
// Self-checking bench for dcs_result_quant: directed scenarios plus randomized
// frames, checked against a frame-level reference model.
module tb_dcs_result_quant;
    import dcs_pkg::*;

    typedef struct packed {
        logic [7:0]  d;
        logic [2:0]  i;
        logic        l;
        logic [2:0]  mi;
        logic [31:0] mv;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    dcs_word_t       in_data;
    logic [SH_W-1:0] cfg_shift;
    logic            clr_err;
    logic            ovf;
    logic            frm_err;

    dcs_result_quant_if bus();

    dcs_result_quant dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .cfg_shift (cfg_shift),
        .clr_err   (clr_err),
        .ob        (bus),
        .ovf       (ovf),
        .frm_err   (frm_err)
    );

    always #5 clk = ~clk;

    beat_t     exp_q[$];
    beat_t     got_q[$];
    int        n_chk = 0;
    int        n_fail = 0;
    bit        rnd_rdy = 1'b0;
    dcs_word_t fw [8];
    int        fsh;

    // Record each beat that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready)
            got_q.push_back(beat_t'({bus.out_data, bus.out_idx, bus.out_last, bus.max_idx, bus.max_val}));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_q(input longint unsigned x, input int s);
        longint unsigned q;
        if (s == 0) q = x;
        else        q = (x + (64'd1 << (s - 1))) >> s;
        return (q > 64'd255) ? 8'd255 : q[7:0];
    endfunction

    // Model: first-occurring maximum, each word requantized independently.
    task automatic exp_frame();
        int m = 0;
        for (int k = 1; k < 8; k++) if (fw[k] > fw[m]) m = k;
        for (int k = 0; k < 8; k++)
            exp_q.push_back(beat_t'({ref_q(fw[k], fsh), 3'(k), (k == 7), 3'(m), fw[m]}));
    endtask

    task automatic send_frame(input int nw);
        for (int k = 0; k < nw; k++) begin
            tick();
            in_valid  = 1'b1;
            in_data   = fw[k];
            cfg_shift = (k == 0) ? SH_W'(fsh) : SH_W'($urandom);
        end
    endtask

    task automatic idle();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 8; k++) fw[k] = $urandom >> $urandom_range(0, 31);
        fsh = $urandom_range(0, 10);
    endtask

    task automatic drain_check(input string tag);
        int t;
        beat_t g;
        beat_t e;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 600) begin
            tick();
            t++;
        end
        repeat (3) tick();
        chk({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, 64'(g.d),  64'(e.d));
            chk({tag, "_idx"},  64'(g.i),  64'(e.i));
            chk({tag, "_last"}, 64'(g.l),  64'(e.l));
            chk({tag, "_midx"}, 64'(g.mi), 64'(e.mi));
            chk({tag, "_mval"}, 64'(g.mv), 64'(e.mv));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_head(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"},  64'(bus.out_data),  64'(exp_q[0].d));
        chk({tag, "_idx"},   64'(bus.out_idx),   64'(exp_q[0].i));
        chk({tag, "_midx"},  64'(bus.max_idx),   64'(exp_q[0].mi));
        chk({tag, "_mval"},  64'(bus.max_val),   64'(exp_q[0].mv));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_data"},  64'(bus.out_data),  64'd0);
        chk({tag, "_idx"},   64'(bus.out_idx),   64'd0);
        chk({tag, "_last"},  64'(bus.out_last),  64'd0);
        chk({tag, "_midx"},  64'(bus.max_idx),   64'd0);
        chk({tag, "_mval"},  64'(bus.max_val),   64'd0);
        chk({tag, "_ovf"},   64'(ovf),           64'd0);
        chk({tag, "_ferr"},  64'(frm_err),       64'd0);
    endtask

    task automatic single_frame(input string tag);
        bus.out_ready = 1'b1;
        fw  = '{32'd10, 32'd300, 32'd255, 32'd256, 32'd0, 32'd1000, 32'd7, 32'd300};
        fsh = 0;
        exp_frame();
        send_frame(8);
        idle();
        chk({tag, "_lat_e1"}, 64'(bus.out_valid), 64'd0);
        tick();
        chk({tag, "_lat_e2m"}, 64'(bus.out_valid), 64'd0);
        tick();
        chk({tag, "_lat_e2"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_b0"},     64'(bus.out_data),  64'd10);
        chk({tag, "_midx"},   64'(bus.max_idx),   64'd5);
        chk({tag, "_mval"},   64'(bus.max_val),   64'd1000);
        drain_check(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_shift = '0; clr_err = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        single_frame("single");

        // Rounding and saturation, including the all-ones word.
        fw  = '{32'd5, 32'd6, 32'd1021, 32'd1022, 32'd3, 32'd4, 32'd0, 32'hFFFF_FFFF};
        fsh = 2;
        exp_frame();
        send_frame(8);
        idle();
        drain_check("round");

        // Random frames under random backpressure, at most one frame outstanding.
        rnd_rdy = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int t = 0; t < 400 && got_q.size() + 8 < exp_q.size(); t++) tick();
            rand_frame();
            exp_frame();
            send_frame(8);
            idle();
        end
        drain_check("rand");
        chk("rand_ovf", 64'(ovf), 64'd0);
        rnd_rdy = 1'b0;

        // Ping-pong under backpressure; third frame is dropped.
        bus.out_ready = 1'b0;
        rand_frame(); exp_frame(); send_frame(8); idle();
        repeat (3) tick();
        chk_head("pp_a");
        rand_frame(); exp_frame(); send_frame(8); idle();
        repeat (3) tick();
        chk_head("pp_b");
        chk("pp_ovf0", 64'(ovf), 64'd0);
        rand_frame(); send_frame(8); idle();
        chk("pp_ovf1", 64'(ovf), 64'd1);
        chk_head("pp_c");
        bus.out_ready = 1'b1;
        drain_check("pingpong");
        tick(); clr_err = 1'b1;
        tick(); clr_err = 1'b0;
        chk("ovf_clr", 64'(ovf), 64'd0);

        // All-equal words keep the lowest index as the max.
        for (int k = 0; k < 8; k++) fw[k] = 32'd42;
        fsh = 0;
        exp_frame(); send_frame(8); idle();
        drain_check("tie");

        // Abort after word 3: flag set, nothing emitted, next frame clean.
        rand_frame(); send_frame(4); idle();
        tick();
        chk("abort_ferr", 64'(frm_err), 64'd1);
        repeat (5) tick();
        chk("abort_nout", 64'(bus.out_valid), 64'd0);
        chk("abort_nbeat", 64'(got_q.size()), 64'd0);
        rand_frame(); exp_frame(); send_frame(8); idle();
        drain_check("post_abort");
        tick(); clr_err = 1'b1;
        tick(); clr_err = 1'b0;
        chk("ferr_clr", 64'(frm_err), 64'd0);
        // Abort coinciding with clr_err: set wins.
        rand_frame(); send_frame(2);
        tick(); in_valid = 1'b0; clr_err = 1'b1;
        tick(); clr_err = 1'b0;
        chk("ferr_setwins", 64'(frm_err), 64'd1);
        tick(); clr_err = 1'b1;
        tick(); clr_err = 1'b0;
        chk("ferr_clr2", 64'(frm_err), 64'd0);

        // Beat-7 release of A in the same cycle as word 0 of C.
        bus.out_ready = 1'b0;
        rand_frame(); exp_frame(); send_frame(8); idle();
        rand_frame(); exp_frame(); send_frame(8); idle();
        repeat (3) tick();
        chk_head("simul_a");
        rand_frame(); exp_frame();
        tick(); bus.out_ready = 1'b1;
        repeat (6) tick();
        send_frame(8);
        idle();
        chk("simul_ovf", 64'(ovf), 64'd0);
        drain_check("simul");

        // Asynchronous reset mid-drain.
        bus.out_ready = 1'b1;
        rand_frame(); send_frame(8); idle();
        repeat (5) tick();
        tick(); bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_all_zero("arst");
        got_q.delete();
        exp_q.delete();
        tick(); rst = 1'b0; bus.out_ready = 1'b1;
        repeat (4) tick();
        chk("arst_lost", 64'(bus.out_valid), 64'd0);
        chk("arst_nbeat", 64'(got_q.size()), 64'd0);
        single_frame("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
